// File: rtl/sec_jmp_guard.sv
// Secure-jump target guard: checks each requested jump address against a table
// of programmable executable windows plus an alignment rule, and registers the
// result (1-cycle latency, valid/ready on both sides). Blocked targets come out
// as address 0 with ok=0 and are tallied in a sticky flag and saturating counter.
module sec_jmp_guard #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned N_REGIONS  = 4,
  parameter int unsigned ALIGN_BITS = 1,
  parameter int unsigned CNT_W      = 16,
  parameter logic [ADDR_W-1:0] DEF_BASE  = 64'h0000_0000_8000_0000,
  parameter logic [ADDR_W-1:0] DEF_LIMIT = 64'h0000_0000_FFFF_FFFF,
  localparam int unsigned IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_ok,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_limit,
  input  logic              cfg_en,
  input  logic              cfg_lock,
  output logic              cfg_err,
  output logic              locked,
  input  logic              viol_clr,
  output logic              viol_sticky,
  output logic [CNT_W-1:0]  viol_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [ADDR_W-1:0] base_q  [N_REGIONS];
  logic [ADDR_W-1:0] limit_q [N_REGIONS];
  logic              en_q    [N_REGIONS];

  logic              out_valid_q, out_ok_q, cfg_err_q, locked_q, sticky_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_d;

  logic              aligned, hit, legal, accept, blocked;
  logic              idx_ok, cfg_wr_ok;
  logic [31:0]       idx_ext;

  // Upstream may push whenever the output slot is empty or being drained.
  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  if (ALIGN_BITS > 0) begin : g_align
    assign aligned = (in_addr[ALIGN_BITS-1:0] == '0);
  end else begin : g_no_align
    assign aligned = 1'b1;
  end

  // Window match against the current (pre-write) table; limit < base never hits.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < N_REGIONS; i++) begin
      if (en_q[i] && (base_q[i] <= in_addr) && (in_addr <= limit_q[i])) begin
        hit = 1'b1;
      end
    end
  end

  assign legal   = aligned & hit;
  assign blocked = accept & !legal;

  assign idx_ext   = 32'(cfg_idx);
  assign idx_ok    = (idx_ext < N_REGIONS);
  assign cfg_wr_ok = cfg_we & !locked_q & idx_ok;

  // Violation bookkeeping: clear first, so a same-cycle block lands on a count of 1.
  always_comb begin
    cnt_d    = viol_clr ? '0 : cnt_q;
    sticky_d = (sticky_q & !viol_clr) | blocked;
    if (blocked && (cnt_d != CntMax)) begin
      cnt_d = cnt_d + 1'b1;
    end
  end

  // Result register: load on accept, drop valid once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_ok_q    <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= legal ? in_addr : '0;
      out_ok_q    <= legal;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Window table: region 0 comes up open on the default range, others disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
        base_q[i]  <= (i == 0) ? DEF_BASE : '0;
        limit_q[i] <= (i == 0) ? DEF_LIMIT : '0;
        en_q[i]    <= (i == 0);
      end
    end else begin
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
        if (cfg_wr_ok && (idx_ext == i)) begin
          base_q[i]  <= cfg_base;
          limit_q[i] <= cfg_limit;
          en_q[i]    <= cfg_en;
        end
      end
    end
  end

  // Lock is sticky until reset; refused writes pulse cfg_err for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      locked_q  <= locked_q | cfg_lock;
      cfg_err_q <= cfg_we & !cfg_wr_ok;
    end
  end

  // Violation state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_ok      = out_ok_q;
  assign cfg_err     = cfg_err_q;
  assign locked      = locked_q;
  assign viol_sticky = sticky_q;
  assign viol_cnt    = cnt_q;

endmodule

// File: tb/tb_sec_jmp_guard.sv
// Bench for sec_jmp_guard: directed scenarios followed by random traffic, all
// checked against a transaction-level model (window list + result queue).
module tb_sec_jmp_guard;

  localparam int unsigned NR    = 3;
  localparam int unsigned CW    = 2;
  localparam int          CMAX  = 3;
  localparam int unsigned ALIGN = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_ok;
  logic [63:0] in_addr, out_addr, cfg_base, cfg_limit;
  logic        cfg_we, cfg_en, cfg_lock, cfg_err, locked, viol_clr, viol_sticky;
  logic [1:0]  cfg_idx;
  logic [CW-1:0] viol_cnt;

  sec_jmp_guard #(
    .ADDR_W    (64),
    .N_REGIONS (NR),
    .ALIGN_BITS(ALIGN),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_ok     (out_ok),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_base   (cfg_base),
    .cfg_limit  (cfg_limit),
    .cfg_en     (cfg_en),
    .cfg_lock   (cfg_lock),
    .cfg_err    (cfg_err),
    .locked     (locked),
    .viol_clr   (viol_clr),
    .viol_sticky(viol_sticky),
    .viol_cnt   (viol_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model state
  logic [63:0] m_base [NR];
  logic [63:0] m_lim  [NR];
  bit          m_en   [NR];
  bit          m_locked, m_sticky, m_err;
  int          m_cnt;
  logic [64:0] m_q[$];  // {ok, addr} of the result waiting at the output

  function automatic bit m_legal(input logic [63:0] a);
    if ((a % (64'd1 << ALIGN)) != 0) return 1'b0;
    for (int i = 0; i < NR; i++)
      if (m_en[i] && a >= m_base[i] && a <= m_lim[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = (i == 0) ? 64'h8000_0000 : 64'h0;
      m_lim[i]  = (i == 0) ? 64'hFFFF_FFFF : 64'h0;
      m_en[i]   = (i == 0);
    end
    m_locked = 0; m_sticky = 0; m_err = 0; m_cnt = 0;
    m_q.delete();
  endtask

  task automatic idle();
    in_valid = 0; in_addr = '0; out_ready = 1; cfg_we = 0; cfg_idx = '0;
    cfg_base = '0; cfg_limit = '0; cfg_en = 0; cfg_lock = 0; viol_clr = 0;
  endtask

  task automatic check_state(input string pfx);
    check_eq({pfx, ".out_valid"}, 64'(out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_eq({pfx, ".out_addr"}, out_addr, m_q[0][63:0]);
      check_eq({pfx, ".out_ok"}, 64'(out_ok), 64'(m_q[0][64]));
    end
    check_eq({pfx, ".cfg_err"}, 64'(cfg_err), 64'(m_err));
    check_eq({pfx, ".locked"}, 64'(locked), 64'(m_locked));
    check_eq({pfx, ".sticky"}, 64'(viol_sticky), 64'(m_sticky));
    check_eq({pfx, ".cnt"}, 64'(viol_cnt), 64'(m_cnt));
  endtask

  // One clock with the inputs currently driven; model advanced, then DUT compared.
  task automatic step(input string pfx);
    bit rdy, acc, ok;
    #1;
    rdy = (m_q.size() == 0) || out_ready;
    check_eq({pfx, ".in_ready"}, 64'(in_ready), 64'(rdy));
    acc = in_valid && rdy;
    ok  = m_legal(in_addr);
    if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
    if (acc) m_q.push_back({ok, ok ? in_addr : 64'h0});
    if (viol_clr) begin m_cnt = 0; m_sticky = 0; end
    if (acc && !ok) begin m_sticky = 1; m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX; end
    m_err = cfg_we && (m_locked || int'(cfg_idx) >= NR);
    if (cfg_we && !m_locked && int'(cfg_idx) < NR) begin
      m_base[cfg_idx] = cfg_base; m_lim[cfg_idx] = cfg_limit; m_en[cfg_idx] = cfg_en;
    end
    if (cfg_lock) m_locked = 1;
    @(posedge clk);
    #1;
    check_state(pfx);
  endtask

  task automatic req(input string pfx, input logic [63:0] a);
    idle(); in_valid = 1; in_addr = a; step(pfx);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    m_reset();
    check_state("rst");
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic logic [63:0] pick_addr();
    int k = int'($urandom_range(0, 5));
    int r = int'($urandom_range(0, NR - 1));
    case (k)
      0: return m_base[r];
      1: return m_lim[r];
      2: return m_base[r] - 64'($urandom_range(0, 2));
      3: return m_lim[r] + 64'($urandom_range(0, 2));
      4: return {32'h0, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    idle();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("init");
    @(negedge clk);
    rst_n = 1;

    // Reset-state default window and alignment
    req("t1", 64'h00FF_EEDD);
    req("t2a", 64'hA219_9872);
    req("t2b", 64'hA219_9873);
    idle(); step("t2idle");

    // Window write, with a same-cycle request seeing the old table
    idle(); cfg_we = 1; cfg_idx = 1; cfg_base = 64'h1000; cfg_limit = 64'h1FFF; cfg_en = 1;
    in_valid = 1; in_addr = 64'h1000; step("t3wr");
    req("t3a", 64'h1000);
    req("t3b", 64'h1FFE);
    req("t3c", 64'h2000);
    req("t3d", 64'h0FFE);
    idle(); viol_clr = 1; step("t3clr");

    // Out-of-range index, then lock and a refused write
    idle(); cfg_we = 1; cfg_idx = 2'd3; cfg_base = 64'h0; cfg_limit = '1; cfg_en = 1; step("t4idx");
    idle(); cfg_lock = 1; step("t4lock");
    idle(); cfg_we = 1; cfg_idx = 1; cfg_base = 64'h0; cfg_limit = '1; cfg_en = 1; step("t4wr");
    req("t4a", 64'h00FF_EEDD);
    req("t4b", 64'h1000);

    // Back-pressure: stream with the consumer stalled, then release
    for (int i = 0; i < 4; i++) begin
      idle(); in_valid = 1; in_addr = 64'h8000_0000 + 64'(i * 2); out_ready = (i == 3);
      if (i == 1 || i == 2) in_addr = 64'h4;
      step("t5s");
    end
    for (int i = 0; i < 3; i++) begin
      idle(); in_valid = 1; in_addr = 64'h9000_0000 + 64'(i * 4); step("t5r");
    end
    idle(); in_valid = 1; in_addr = 64'h9000_0100; out_ready = 0; step("t5m");
    do_reset();

    // Counter saturation and clear-with-block
    for (int i = 0; i < 5; i++) req("t6", 64'h3);
    idle(); viol_clr = 1; in_valid = 1; in_addr = 64'h5; step("t6clr");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_addr   = pick_addr();
      out_ready = ($urandom_range(0, 9) < 7);
      viol_clr  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_we    = 1;
        cfg_idx   = 2'($urandom_range(0, 3));
        cfg_base  = {32'h0, $urandom()};
        cfg_limit = cfg_base + 64'($urandom_range(0, 32'h0100_0000));
        if ($urandom_range(0, 9) == 0) cfg_limit = cfg_base - 64'd1;
        cfg_en    = ($urandom_range(0, 4) != 0);
      end
      cfg_lock = ($urandom_range(0, 199) == 0);
      step("rnd");
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
